rv32_multicycle_ctrl: RTL and testbench
=======================================

Name: rv32_multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU, register file and the single shared memory port.
- Consumes the decoder's field outputs (opcode, funct3, funct7 bit 5) plus the branch comparator and memory ready. Drives every datapath enable and mux select.
- Counts retired instructions and traps on illegal encodings or a memory timeout.

Parameters:
- CNT_W, 32, width of retire_count.
- MEM_TIMEOUT, 255, max cycles a memory request may wait for mem_ready before trapping (>=1).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  decoder opcode (registered IR field).
- funct3  in  3  decoder funct3.
- funct7_5  in  1  instr[30].
- br_taken  in  1  branch comparator result for the current funct3.
- mem_ready  in  1  memory completes the request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  store request.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_write  out  1  latch fetched instruction.
- pc_write  out  1  update PC.
- pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit0 cleared.
- reg_write  out  1  register file write enable.
- wb_src  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = imm.
- alu_a_src  out  1  0 = rs1, 1 = PC.
- alu_b_src  out  1  0 = rs2, 1 = imm.
- alu_ctrl  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- trap_cause  out  2  0 = none, 1 = illegal, 2 = mem timeout.
- retired  out  1  one-cycle pulse per completed instruction.
- retire_count  out  CNT_W  retired instruction count.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-request):
  - Next state FETCH; retire_count=0; trap_cause=0; wait counter=0.
  - All enables 0, all selects 0, alu_ctrl=ADD.
- Outputs are combinational from state and the current opcode/funct3/funct7_5. Any output not named for a state is 0.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - ir_write=1 only in the cycle mem_ready=1; that cycle → DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Legality check. Illegal encodings:
    - unknown opcode;
    - LOAD with funct3 in {011, 110, 111};
    - STORE with funct3 > 010;
    - BRANCH with funct3 in {010, 011};
    - OP-IMM with funct3=001 and funct7_5=1.
  - Illegal → TRAP with trap_cause=1; else → EXEC.
- EXEC, alu_ctrl selection:
  - R-type: from funct3; funct7_5 selects SUB for 000 and SRA for 101.
  - OP-IMM: alu_b_src=1; funct7_5 honoured only for 101.
  - LOAD, STORE, JALR, AUIPC: ADD with alu_b_src=1; AUIPC also sets alu_a_src=1.
  - BRANCH: SUB.
- EXEC, transitions:
  - BRANCH: pc_write=1, pc_src = br_taken ? 1 : 0, retired=1 → FETCH.
  - LOAD/STORE → MEM.
  - All others → WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - Hold until mem_ready.
  - STORE completes with pc_write=1, pc_src=0, retired=1 → FETCH.
  - LOAD completes → WB.
- WB:
  - reg_write=1 and pc_write=1, then → FETCH with retired=1.
  - wb_src: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - pc_src: JAL=1, JALR=2, else 0.
- Timeout:
  - Wait counter increments each cycle mem_req=1 && mem_ready=0; it clears on mem_ready or on a state change.
  - When the counter reaches MEM_TIMEOUT while still waiting → TRAP with trap_cause=2.
- TRAP:
  - All enables 0, no memory requests.
  - Held until rst; trap_cause stays stable.
- mem_ready outside FETCH/MEM is ignored.
- retire_count increments on each retired pulse and wraps modulo 2^CNT_W.
- Latency with mem_ready asserted in the request cycle:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - Each extra wait cycle adds 1.

Test Plan:
- ADD (R, funct3=000, funct7_5=0), mem_ready always 1 → states 0,1,2,4,0; alu_ctrl=0 in EXEC; reg_write=1, wb_src=0, pc_src=0 in WB; retire_count=1.
- LW (opcode 0000011, funct3=010), fetch ready after 2 waits, MEM ready after 3 waits → FETCH 3 cycles, MEM 4 cycles with mem_addr_sel=1, mem_we=0; WB wb_src=1; total 10 cycles.
- BEQ: run once with br_taken=1, once with br_taken=0 → pc_src=1 then 0; pc_write and retired in EXEC; reg_write never 1; 3 cycles each.
- Encoding 0x0000707F (opcode 1111111) → TRAP in cycle 3 with trap_cause=1; stays in TRAP for 20 cycles; rst → FETCH, trap_cause=0.
- Store with mem_ready held 0 and MEM_TIMEOUT=4 → TRAP after 4 waiting cycles, trap_cause=2, mem_req=0 afterwards.
- rst asserted in MEM during a pending SW → next cycle FETCH; mem_we=0, retire_count=0; a subsequent JALR completes with pc_src=2, wb_src=2.

Source files
------------

// File: rtl/rv32_multicycle_ctrl_if.sv
// rv32_multicycle_ctrl_if: decoder fields, memory handshake and datapath controls of the multicycle core
interface rv32_multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7_5, br_taken, mem_ready;
  logic mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, alu_a_src, alu_b_src, retired;
  logic [1:0] pc_src, wb_src, trap_cause;
  logic [3:0] alu_ctrl;
  logic [2:0] state;
  logic [CNT_W-1:0] retire_count;
  modport master (
    input opcode, funct3, funct7_5, br_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, alu_a_src, alu_b_src,
    output retired, pc_src, wb_src, trap_cause, alu_ctrl, state, retire_count
  );
  modport slave (
    output opcode, funct3, funct7_5, br_taken, mem_ready,
    input mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, alu_a_src, alu_b_src,
    input retired, pc_src, wb_src, trap_cause, alu_ctrl, state, retire_count
  );
endinterface

// File: rtl/rv32_multicycle_ctrl.sv
// rv32_multicycle_ctrl: fetch/decode/exec/mem/wb sequencer for the RV32I multicycle core
module rv32_multicycle_ctrl #(
  parameter int CNT_W = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  rv32_multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t st;
  logic [WW-1:0] wait_cnt;
  logic [1:0] cause;
  logic [CNT_W-1:0] cnt;
  logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
  logic legal, waiting, timeout;
  logic [3:0] f3_alu;
  assign is_lui = bus.opcode == 7'b0110111;
  assign is_auipc = bus.opcode == 7'b0010111;
  assign is_jal = bus.opcode == 7'b1101111;
  assign is_jalr = bus.opcode == 7'b1100111;
  assign is_branch = bus.opcode == 7'b1100011;
  assign is_load = bus.opcode == 7'b0000011;
  assign is_store = bus.opcode == 7'b0100011;
  assign is_opimm = bus.opcode == 7'b0010011;
  assign is_op = bus.opcode == 7'b0110011;
  assign legal = is_lui | is_auipc | is_jal | is_jalr | is_op
    | (is_load && !(bus.funct3 inside {3'b011, 3'b110, 3'b111}))
    | (is_store && bus.funct3 <= 3'd2)
    | (is_branch && bus.funct3 != 3'd2 && bus.funct3 != 3'd3)
    | (is_opimm && !(bus.funct3 == 3'd1 && bus.funct7_5));
  // funct3 1..4 map to codes 2..5 and 6/7 to 8/9; 000 and 101 carry the funct7_5 variant
  assign f3_alu = bus.funct3 == 3'd0 ? {3'b000, is_op & bus.funct7_5}
                : bus.funct3 == 3'd5 ? {3'b011, bus.funct7_5}
                : {1'b0, bus.funct3} + 4'd1 + {3'b000, bus.funct3[2] & bus.funct3[1]};
  assign waiting = bus.mem_req && !bus.mem_ready;
  assign timeout = waiting && wait_cnt == WW'(MEM_TIMEOUT - 1);
  assign bus.state = st;
  assign bus.trap_cause = cause;
  assign bus.retire_count = cnt;
  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.alu_a_src = 1'b0;
    bus.alu_b_src = 1'b0;
    bus.retired = 1'b0;
    bus.pc_src = 2'd0;
    bus.wb_src = 2'd0;
    bus.alu_ctrl = 4'd0;
    if (!rst)
      case (st)
        FETCH: begin
          bus.mem_req = 1'b1;
          bus.ir_write = bus.mem_ready;
        end
        EXEC: begin
          bus.alu_ctrl = (is_op | is_opimm) ? f3_alu : is_branch ? 4'd1 : 4'd0;
          bus.alu_b_src = is_opimm | is_load | is_store | is_jalr | is_auipc;
          bus.alu_a_src = is_auipc;
          bus.pc_write = is_branch;
          bus.retired = is_branch;
          bus.pc_src = {1'b0, is_branch & bus.br_taken};
        end
        MEM: begin
          bus.mem_req = 1'b1;
          bus.mem_addr_sel = 1'b1;
          bus.mem_we = is_store;
          bus.pc_write = is_store & bus.mem_ready;
          bus.retired = is_store & bus.mem_ready;
        end
        WB: begin
          bus.reg_write = 1'b1;
          bus.pc_write = 1'b1;
          bus.retired = 1'b1;
          bus.wb_src = is_load ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
          bus.pc_src = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= FETCH;
      wait_cnt <= '0;
      cause <= 2'd0;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(bus.retired);
      wait_cnt <= (waiting && !timeout) ? wait_cnt + WW'(1) : '0;
      cause <= timeout ? 2'd2 : (st == DECODE && !legal) ? 2'd1 : cause;
      case (st)
        FETCH: st <= bus.mem_ready ? DECODE : timeout ? TRAP : FETCH;
        DECODE: st <= legal ? EXEC : TRAP;
        EXEC: st <= is_branch ? FETCH : (is_load | is_store) ? MEM : WB;
        MEM: st <= bus.mem_ready ? (is_store ? FETCH : WB) : timeout ? TRAP : MEM;
        WB: st <= FETCH;
        default: st <= TRAP;
      endcase
    end
endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// tb_rv32_multicycle_ctrl: random and directed stimulus against an instruction-level reference model
module tb_rv32_multicycle_ctrl;
  localparam int TO = 4;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011, OPI = 7'b0010011, OPR = 7'b0110011;
  typedef struct packed {
    logic mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, alu_a_src, alu_b_src, retired;
    logic [1:0] pc_src, wb_src;
    logic [3:0] alu_ctrl;
  } outs_t;
  logic clk = 1'b0, rst = 1'b1, go = 1'b0;
  int checks = 0, errors = 0;
  int alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  logic [6:0] ops [9] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR};
  int m_st = 0, m_wait = 0, m_cause = 0, nst, ncause;
  logic [7:0] m_cnt = 8'd0;
  outs_t e, d;
  logic waiting;
  rv32_multicycle_ctrl_if #(.CNT_W(8)) bus ();
  rv32_multicycle_ctrl #(.CNT_W(8), .MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign d = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_write, bus.pc_write, bus.reg_write,
              bus.alu_a_src, bus.alu_b_src, bus.retired, bus.pc_src, bus.wb_src, bus.alu_ctrl};

  function automatic bit legal(logic [6:0] op, logic [2:0] f3, logic f75);
    case (op)
      LUI, AUIPC, JAL, JALR, OPR: return 1'b1;
      LD: return !(f3 == 3 || f3 == 6 || f3 == 7);
      ST: return f3 < 3;
      BR: return f3 != 2 && f3 != 3;
      OPI: return !(f3 == 1 && f75);
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t exp_out(int st, logic [6:0] op, logic [2:0] f3, logic f75, logic br, logic rdy, logic r);
    outs_t o = '0;
    if (r) return o;
    case (st)
      0: begin o.mem_req = 1; o.ir_write = rdy; end
      2: begin
        if (op == OPR) o.alu_ctrl = 4'(alu_tab[f3] + int'((f3 == 0 || f3 == 5) && f75));
        else if (op == OPI) begin o.alu_b_src = 1; o.alu_ctrl = 4'(alu_tab[f3] + int'(f3 == 5 && f75)); end
        else if (op == LD || op == ST || op == JALR || op == AUIPC) begin o.alu_b_src = 1; o.alu_a_src = op == AUIPC; end
        else if (op == BR) begin o.alu_ctrl = 1; o.pc_write = 1; o.retired = 1; o.pc_src = br ? 2'd1 : 2'd0; end
      end
      3: begin
        o.mem_req = 1; o.mem_addr_sel = 1; o.mem_we = op == ST;
        o.pc_write = op == ST && rdy; o.retired = op == ST && rdy;
      end
      4: begin
        o.reg_write = 1; o.pc_write = 1; o.retired = 1;
        o.wb_src = op == LD ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : op == LUI ? 2'd3 : 2'd0;
        o.pc_src = op == JAL ? 2'd1 : op == JALR ? 2'd2 : 2'd0;
      end
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    e = exp_out(m_st, bus.opcode, bus.funct3, bus.funct7_5, bus.br_taken, bus.mem_ready, rst);
    waiting = e.mem_req && !bus.mem_ready;
    nst = m_st;
    ncause = m_cause;
    if (m_st == 0 || m_st == 3) begin
      if (bus.mem_ready) nst = m_st == 0 ? 1 : (bus.opcode == ST ? 0 : 4);
      else if (m_wait + 1 == TO) begin nst = 5; ncause = 2; end
    end else if (m_st == 1) begin
      nst = legal(bus.opcode, bus.funct3, bus.funct7_5) ? 2 : 5;
      if (nst == 5) ncause = 1;
    end else if (m_st == 2) nst = bus.opcode == BR ? 0 : (bus.opcode == LD || bus.opcode == ST) ? 3 : 4;
    else if (m_st == 4) nst = 0;
  end

  always @(posedge clk)
    if (rst) begin
      m_st <= 0; m_wait <= 0; m_cause <= 0; m_cnt <= 8'd0;
    end else begin
      m_st <= nst; m_cause <= ncause; m_cnt <= m_cnt + 8'(e.retired);
      m_wait <= (nst == m_st && waiting) ? m_wait + 1 : 0;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (go) begin
      chk("outputs", 32'(d), 32'(e));
      chk("state", 32'(bus.state), m_st);
      chk("trap_cause", 32'(bus.trap_cause), m_cause);
      chk("retire_count", 32'(bus.retire_count), 32'(m_cnt));
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f75;
  endtask

  task automatic do_rst();
    rst = 1'b1; bus.mem_ready = 1'b1;
    #1 chk("rst mem_req", 32'(bus.mem_req), 0);
    tick();
    rst = 1'b0;
  endtask

  // sts: expected state per cycle; rd: mem_ready per cycle ('x' = random, should be ignored)
  task automatic run(input string nm, input string sts, input string rd);
    for (int i = 0; i < sts.len(); i++) begin
      bus.mem_ready = rd[i] == "x" ? 1'($urandom) : rd[i] == "1";
      #1 chk(nm, 32'(bus.state), 32'(sts[i]) - 32'd48);
      tick();
    end
  endtask

  initial begin
    set_ins(OPR, 3'd0, 1'b0);
    bus.br_taken = 1'b0; bus.mem_ready = 1'b0;
    tick(); tick();
    go = 1'b1;
    do_rst();
    #1 chk("reset state", 32'(bus.state), 0);
    chk("reset cause", 32'(bus.trap_cause), 0);
    chk("reset count", 32'(bus.retire_count), 0);
    run("add", "012", "1xx");
    #1 chk("add wb state", 32'(bus.state), 4);
    chk("add reg_write", 32'(bus.reg_write), 1);
    chk("add wb_src", 32'(bus.wb_src), 0);
    chk("add pc_src", 32'(bus.pc_src), 0);
    tick();
    #1 chk("add count", 32'(bus.retire_count), 1);
    set_ins(LD, 3'd2, 1'b0);
    run("lw", "0001233334", "001xx0001x");
    #1 chk("lw count", 32'(bus.retire_count), 2);
    for (int t = 1; t >= 0; t--) begin
      set_ins(BR, 3'd0, 1'b0);
      bus.br_taken = 1'(t);
      run("beq", "01", "1x");
      #1 chk("beq pc_src", 32'(bus.pc_src), 32'(t));
      chk("beq pc_write", 32'(bus.pc_write), 1);
      chk("beq retired", 32'(bus.retired), 1);
      chk("beq reg_write", 32'(bus.reg_write), 0);
      tick();
    end
    #1 chk("beq count", 32'(bus.retire_count), 4);
    set_ins(7'h7F, 3'd7, 1'b0);
    run("illegal", "01", "1x");
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom);
      #1 chk("illegal trap", {bus.state, bus.trap_cause, bus.mem_req}, {3'd5, 2'd1, 1'b0});
      tick();
    end
    do_rst();
    #1 chk("trap reset", {bus.state, bus.trap_cause}, 0);
    set_ins(ST, 3'd2, 1'b0);
    run("sw timeout", "0123333", "1xx0000");
    #1 chk("timeout trap", {bus.state, bus.trap_cause, bus.mem_req}, {3'd5, 2'd2, 1'b0});
    tick();
    do_rst();
    set_ins(OPR, 3'd0, 1'b0);
    run("add2", "0124", "1xxx");
    set_ins(ST, 3'd2, 1'b0);
    run("sw", "0123", "1xx0");
    rst = 1'b1; bus.mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1 chk("mid-mem rst", {bus.state, bus.mem_we}, 0);
    chk("mid-mem count", 32'(bus.retire_count), 0);
    set_ins(JALR, 3'd0, 1'b0);
    run("jalr", "012", "1xx");
    #1 chk("jalr pc_src", 32'(bus.pc_src), 2);
    chk("jalr wb_src", 32'(bus.wb_src), 2);
    tick();
    do_rst();
    set_ins(BR, 3'd0, 1'b0);
    for (int i = 0; i < 257; i++) begin
      bus.br_taken = 1'($urandom);
      run("wrap", "012", "1xx");
    end
    #1 chk("count wrap", 32'(bus.retire_count), 1);
    for (int i = 0; i < 4000; i++) begin
      if (m_st == 0) begin
        int k = $urandom_range(0, 9);
        set_ins(k == 9 ? 7'($urandom) : ops[k], 3'($urandom), 1'($urandom));
      end
      bus.br_taken = 1'($urandom);
      bus.mem_ready = $urandom_range(0, 3) != 0;
      rst = (m_st == 5 && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0;
      tick();
    end
    rst = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
